// File: rtl/wb_rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// a constant-evaluable clog2 and the stretch/gap counter width rule.
package wb_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // One extra bit beyond the largest reload value keeps the down-counter unambiguous.
  function automatic int seq_cnt_width(input int stretch_cyc, input int gap_cyc);
    return clog2((stretch_cyc > gap_cyc) ? stretch_cyc : gap_cyc) + 32'sd1;
  endfunction

  localparam int SEQ_CNT_W = seq_cnt_width(32'sd16, 32'sd4);

endpackage

// File: rtl/wb_sync_chain.sv
// Multi-flop synchroniser with a selectable asynchronous reset value; used both
// for reset-deassertion synchronisation and for bringing the PLL lock into wb_clk_o.
module wb_sync_chain #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic wb_clk_o,
  input  logic async_rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_r;

  // Shift chain; async_rst forces every stage to RESET_VAL.
  always_ff @(posedge wb_clk_o or posedge async_rst) begin
    if (async_rst) begin
      chain_r <= {DEPTH{RESET_VAL}};
    end else begin
      chain_r <= {chain_r[DEPTH-2:0], d};
    end
  end

  assign q = chain_r[DEPTH-1];

endmodule

// File: rtl/wb_rst_sequencer.sv
// Reset sequencer: waits for a clean reset release and PLL lock, stretches,
// then releases the channel resets one by one with a fixed gap.
module wb_rst_sequencer
  import wb_rst_seq_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYC = 16,
  parameter int GAP_CYC     = 4
) (
  input  logic            wb_clk_o,
  input  logic            async_rst,
  input  logic            pll_locked_i,
  input  logic            soft_rst_i,
  output logic [N_CH-1:0] rst_o,
  output logic            all_rel_o,
  output logic            busy_o,
  output logic [7:0]      rst_cnt_o
);

  localparam int               CNT_W      = seq_cnt_width(STRETCH_CYC, GAP_CYC);
  localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic            rst_sync_s;
  logic            lock_sync_s;
  seq_state_t      state_r;
  seq_state_t      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [N_CH-1:0] rst_r;
  logic [N_CH-1:0] rst_nxt_s;
  logic [N_CH-1:0] rst_shift_s;
  logic            all_rel_r;
  logic            all_rel_nxt_s;
  logic            busy_r;
  logic            busy_nxt_s;
  logic [7:0]      rst_cnt_r;
  logic [7:0]      rst_cnt_nxt_s;
  logic            cnt_zero_s;
  logic            step_s;
  logic            rel_last_s;

  wb_sync_chain #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_rst_sync (
    .wb_clk_o (wb_clk_o),
    .async_rst(async_rst),
    .d        (1'b0),
    .q        (rst_sync_s)
  );

  wb_sync_chain #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_lock_sync (
    .wb_clk_o (wb_clk_o),
    .async_rst(async_rst),
    .d        (pll_locked_i),
    .q        (lock_sync_s)
  );

  // Channels release in index order, so the next release pattern is a left shift.
  assign rst_shift_s = rst_r << 1'b1;
  assign rel_last_s  = (rst_shift_s == {N_CH{1'b0}});
  assign cnt_zero_s  = (cnt_r == CNT_ZERO);
  assign step_s      = cnt_zero_s && ((state_r == ST_STRETCH) || (state_r == ST_RELEASE));

  // State register.
  always_ff @(posedge wb_clk_o or posedge async_rst) begin
    if (async_rst) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; lock loss outranks any pending release step.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HOLD: begin
        if (!rst_sync_s && lock_sync_s) state_nxt_s = ST_STRETCH;
        else                            state_nxt_s = ST_HOLD;
      end
      ST_STRETCH: begin
        if (!lock_sync_s)    state_nxt_s = ST_HOLD;
        else if (cnt_zero_s) state_nxt_s = rel_last_s ? ST_RUN : ST_RELEASE;
        else                 state_nxt_s = ST_STRETCH;
      end
      ST_RELEASE: begin
        if (!lock_sync_s)                  state_nxt_s = ST_HOLD;
        else if (cnt_zero_s && rel_last_s) state_nxt_s = ST_RUN;
        else                               state_nxt_s = ST_RELEASE;
      end
      ST_RUN: begin
        if (!lock_sync_s || soft_rst_i) state_nxt_s = ST_HOLD;
        else                            state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_HOLD;
    endcase
  end

  // Output/datapath next values: counter reloads on state entry and per gap step.
  always_comb begin
    cnt_nxt_s     = cnt_r;
    rst_nxt_s     = rst_r;
    rst_cnt_nxt_s = rst_cnt_r;
    all_rel_nxt_s = (state_nxt_s == ST_RUN);
    busy_nxt_s    = (state_nxt_s != ST_RUN);

    if (state_nxt_s == ST_STRETCH && state_r != ST_STRETCH) begin
      cnt_nxt_s = STRETCH_LD;
    end else if (state_nxt_s == ST_RELEASE && (state_r != ST_RELEASE || cnt_zero_s)) begin
      cnt_nxt_s = GAP_LD;
    end else if (state_nxt_s != state_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (!cnt_zero_s) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if (state_nxt_s == ST_HOLD) begin
      rst_nxt_s = {N_CH{1'b1}};
    end else if (step_s) begin
      rst_nxt_s = rst_shift_s;
    end else begin
      rst_nxt_s = rst_r;
    end

    if (state_r == ST_RUN && state_nxt_s == ST_HOLD && rst_cnt_r != 8'hFF) begin
      rst_cnt_nxt_s = rst_cnt_r + 8'd1;
    end else begin
      rst_cnt_nxt_s = rst_cnt_r;
    end
  end

  // Registered outputs and counters; rst_r presets to all-ones asynchronously.
  always_ff @(posedge wb_clk_o or posedge async_rst) begin
    if (async_rst) begin
      cnt_r     <= CNT_ZERO;
      rst_r     <= {N_CH{1'b1}};
      rst_cnt_r <= 8'd0;
      all_rel_r <= 1'b0;
      busy_r    <= 1'b1;
    end else begin
      cnt_r     <= cnt_nxt_s;
      rst_r     <= rst_nxt_s;
      rst_cnt_r <= rst_cnt_nxt_s;
      all_rel_r <= all_rel_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign rst_o     = rst_r;
  assign all_rel_o = all_rel_r;
  assign busy_o    = busy_r;
  assign rst_cnt_o = rst_cnt_r;

endmodule

// File: tb/tb_wb_rst_sequencer.sv
// Directed self-checking bench for wb_rst_sequencer (4-channel default build
// plus a 1-channel build), edges counted from each async_rst release.
module tb_wb_rst_sequencer;

  logic       wb_clk_o = 1'b0;
  logic       async_rst;
  logic       pll_locked_i;
  logic       soft_rst_i;
  logic [3:0] rst_o;
  logic       all_rel_o;
  logic       busy_o;
  logic [7:0] rst_cnt_o;

  logic       async_rst1;
  logic       pll_locked1;
  logic       soft_rst1;
  logic [0:0] rst1;
  logic       all_rel1;
  logic       busy1;
  logic [7:0] rst_cnt1;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt  = 0;
  int base;

  always #10 wb_clk_o = ~wb_clk_o;

  wb_rst_sequencer #(.N_CH(4), .SYNC_STAGES(2), .STRETCH_CYC(16), .GAP_CYC(4)) u_dut (
    .wb_clk_o    (wb_clk_o),
    .async_rst   (async_rst),
    .pll_locked_i(pll_locked_i),
    .soft_rst_i  (soft_rst_i),
    .rst_o       (rst_o),
    .all_rel_o   (all_rel_o),
    .busy_o      (busy_o),
    .rst_cnt_o   (rst_cnt_o)
  );

  wb_rst_sequencer #(.N_CH(1), .SYNC_STAGES(2), .STRETCH_CYC(16), .GAP_CYC(4)) u_dut1 (
    .wb_clk_o    (wb_clk_o),
    .async_rst   (async_rst1),
    .pll_locked_i(pll_locked1),
    .soft_rst_i  (soft_rst1),
    .rst_o       (rst1),
    .all_rel_o   (all_rel1),
    .busy_o      (busy1),
    .rst_cnt_o   (rst_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_o);
    #1;
    ecnt++;
  endtask

  task automatic step_to(input int n);
    while (ecnt < n) step();
  endtask

  task automatic wait_run(input string tag);
    int k;
    k = 0;
    while (all_rel_o !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk(tag, {31'd0, all_rel_o}, 32'd1);
  endtask

  initial begin
    async_rst    = 1'b1;
    pll_locked_i = 1'b1;
    soft_rst_i   = 1'b0;
    async_rst1   = 1'b1;
    pll_locked1  = 1'b1;
    soft_rst1    = 1'b0;

    // Power-up: reset values while async_rst is high.
    #5;
    chk("rst_val_rst_o",   rst_o,     32'hF);
    chk("rst_val_all_rel", all_rel_o, 32'd0);
    chk("rst_val_busy",    busy_o,    32'd1);
    chk("rst_val_cnt",     rst_cnt_o, 32'd0);
    chk("rst_val_ch1",     rst1,      32'd1);
    #22;
    async_rst = 1'b0;
    ecnt = 0;
    step_to(2);
    chk("pu_e2_rst",  rst_o,  32'hF);
    chk("pu_e2_busy", busy_o, 32'd1);
    step_to(18);
    chk("pu_e18_rst", rst_o, 32'hF);
    step_to(19);
    chk("pu_e19_rst", rst_o, 32'hE);
    step_to(22);
    chk("pu_e22_rst", rst_o, 32'hE);
    step_to(23);
    chk("pu_e23_rst", rst_o, 32'hC);
    step_to(27);
    chk("pu_e27_rst", rst_o, 32'h8);
    step_to(30);
    chk("pu_e30_rst",     rst_o,     32'h8);
    chk("pu_e30_all_rel", all_rel_o, 32'd0);
    step_to(31);
    chk("pu_e31_rst",     rst_o,     32'h0);
    chk("pu_e31_all_rel", all_rel_o, 32'd1);
    chk("pu_e31_busy",    busy_o,    32'd0);
    chk("pu_e31_cnt",     rst_cnt_o, 32'd0);

    // Soft reset from RUN, plus an ignored soft pulse during STRETCH.
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    base = ecnt;
    chk("soft_rst_o",   rst_o,     32'hF);
    chk("soft_cnt",     rst_cnt_o, 32'd1);
    chk("soft_all_rel", all_rel_o, 32'd0);
    chk("soft_busy",    busy_o,    32'd1);
    step_to(base + 5);
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    chk("soft_in_stretch_rst", rst_o,     32'hF);
    chk("soft_in_stretch_cnt", rst_cnt_o, 32'd1);
    step_to(base + 16);
    chk("soft_e16_rst", rst_o, 32'hF);
    step_to(base + 17);
    chk("soft_e17_rst", rst_o, 32'hE);
    step_to(base + 28);
    chk("soft_e28_all_rel", all_rel_o, 32'd0);
    step_to(base + 29);
    chk("soft_e29_all_rel", all_rel_o, 32'd1);
    chk("soft_e29_rst",     rst_o,     32'h0);

    // Lock loss after channel 1 released.
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    base = ecnt;
    chk("lk_cnt_before", rst_cnt_o, 32'd2);
    step_to(base + 22);
    chk("lk_s22_rst", rst_o, 32'hC);
    pll_locked_i = 1'b0;
    step_to(base + 24);
    chk("lk_s24_rst", rst_o, 32'hC);
    step_to(base + 25);
    chk("lk_s25_rst",  rst_o,     32'hF);
    chk("lk_s25_cnt",  rst_cnt_o, 32'd2);
    chk("lk_s25_busy", busy_o,    32'd1);
    step_to(base + 35);
    chk("lk_hold_rst",     rst_o,     32'hF);
    chk("lk_hold_all_rel", all_rel_o, 32'd0);
    pll_locked_i = 1'b1;
    base = ecnt;
    step_to(base + 18);
    chk("relock_e18_rst", rst_o, 32'hF);
    step_to(base + 19);
    chk("relock_e19_rst", rst_o, 32'hE);
    chk("relock_cnt",     rst_cnt_o, 32'd2);
    wait_run("relock_run");

    // Soft reset and synced lock loss seen on the same edge.
    pll_locked_i = 1'b0;
    step();
    step();
    chk("coin_still_run", all_rel_o, 32'd1);
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    chk("coin_rst", rst_o,     32'hF);
    chk("coin_cnt", rst_cnt_o, 32'd3);
    step();
    step();
    chk("coin_cnt_hold", rst_cnt_o, 32'd3);
    pll_locked_i = 1'b1;
    wait_run("coin_run");

    // Asynchronous reset in RUN acts before the next edge.
    #4;
    async_rst = 1'b1;
    #1;
    chk("arst_rst_o",   rst_o,     32'hF);
    chk("arst_cnt",     rst_cnt_o, 32'd0);
    chk("arst_all_rel", all_rel_o, 32'd0);
    chk("arst_busy",    busy_o,    32'd1);
    #4;
    async_rst = 1'b0;
    ecnt = 0;
    step_to(18);
    chk("arst_e18_rst", rst_o, 32'hF);
    step_to(19);
    chk("arst_e19_rst", rst_o, 32'hE);
    wait_run("arst_run");

    // Saturation of the re-sequence counter.
    for (int i = 1; i <= 257; i++) begin
      soft_rst_i = 1'b1;
      step();
      soft_rst_i = 1'b0;
      if (i == 254) chk("sat_254", rst_cnt_o, 32'd254);
      if (i == 255) chk("sat_255", rst_cnt_o, 32'd255);
      wait_run("sat_run");
    end
    chk("sat_hold", rst_cnt_o, 32'd255);

    // Single-channel build: rst and all_rel change on the same edge.
    #6;
    async_rst1 = 1'b0;
    ecnt = 0;
    step_to(18);
    chk("ch1_e18_rst",     rst1,     32'd1);
    chk("ch1_e18_all_rel", all_rel1, 32'd0);
    step_to(19);
    chk("ch1_e19_rst",     rst1,     32'd0);
    chk("ch1_e19_all_rel", all_rel1, 32'd1);
    chk("ch1_e19_busy",    busy1,    32'd0);
    chk("ch1_cnt",         rst_cnt1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
